// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
//   Game sequencer between the input debouncers and the snake playfield.
//   It turns button pulses into one-cycle start/step strobes and a direction
//   that stays stable for a whole step period. It also provides a free-running
//   apple seed and a step period that shortens as play goes on.
//
//   Optional feature macro: SNAKE_PAUSE_EN
//     defined   : btn_pause toggles RUN <-> PAUSE
//     undefined : btn_pause is ignored and PAUSE is never entered
//
// Ports
//   clk           clock
//   rst           synchronous, active-high reset
//   btn_start     pulse, begin a new game (also restarts a running game)
//   btn_dir_valid pulse, btn_dir carries a direction request
//   btn_dir       0 up, 1 right, 2 down, 3 left
//   btn_pause     pulse, toggle pause (SNAKE_PAUSE_EN builds only)
//   snake_alive   playfield alive flag (combinational from the field)
//   start         one-cycle playfield init strobe
//   step          one-cycle playfield advance strobe
//   snake_dir     direction presented to the playfield
//   seed          apple seed, low SBITS of the LFSR
//   game_state    0 IDLE, 1 INIT, 2 RUN, 3 PAUSE, 4 OVER
//   step_count    steps issued this game, saturating
//
// State  | meaning
// IDLE   | after reset, waiting for btn_start
// INIT   | single cycle, start strobe, counters cleared
// RUN    | counting ticks, issuing steps, watching snake_alive
// PAUSE  | tick counter held, no steps
// OVER   | snake died, outputs frozen until btn_start
module snake_game_ctrl #(
    parameter int unsigned TICKS_INIT    = 25000000,
    parameter int unsigned TICKS_MIN     = 5000000,
    parameter int unsigned TICKS_DEC     = 1000000,
    parameter int unsigned SPEEDUP_STEPS = 16,
    parameter int unsigned SBITS         = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_dir_valid,
    input  logic [1:0]       btn_dir,
    input  logic             btn_pause,
    input  logic             snake_alive,
    output logic             start,
    output logic             step,
    output logic [1:0]       snake_dir,
    output logic [SBITS-1:0] seed,
    output logic [2:0]       game_state,
    output logic [15:0]      step_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [31:0] P_INIT   = 32'(TICKS_INIT);
    localparam logic [31:0] P_MIN    = 32'(TICKS_MIN);
    localparam logic [31:0] P_DEC    = 32'(TICKS_DEC);
    localparam logic [31:0] SPD_LAST = 32'(SPEEDUP_STEPS - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [1:0]  DIR_RIGHT = 2'd1;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] tick_cnt;
    logic [31:0] period;
    logic [31:0] period_dec;
    logic [31:0] spd_cnt;
    logic [15:0] lfsr;
    logic [15:0] step_cnt;
    logic [1:0]  pend_dir;
    logic [1:0]  dir_q;
    logic        first_run;
    logic        tick_hit;
    logic        death;
    logic        step_int;

`ifndef SNAKE_PAUSE_EN
    logic unused_btn_pause;
    assign unused_btn_pause = btn_pause;
`endif

    // The field is still settling from the start strobe during the first RUN
    // cycle, so its alive flag is not trusted there.
    assign tick_hit = (tick_cnt == period - 32'd1);
    assign death    = (state == S_RUN) && !first_run && !snake_alive;
    assign step_int = (state == S_RUN) && tick_hit && !death;

    // Clamp before subtracting so the period can never wrap below TICKS_MIN.
    assign period_dec = (period >= P_MIN + P_DEC) ? (period - P_DEC) : P_MIN;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (btn_start) state_nxt = S_INIT;
            end
            S_INIT: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (btn_start)  state_nxt = S_INIT;
                else if (death) state_nxt = S_OVER;
`ifdef SNAKE_PAUSE_EN
                else if (btn_pause) state_nxt = S_PAUSE;
`endif
            end
`ifdef SNAKE_PAUSE_EN
            S_PAUSE: begin
                if (btn_start)      state_nxt = S_INIT;
                else if (btn_pause) state_nxt = S_RUN;
            end
`endif
            S_OVER: begin
                if (btn_start) state_nxt = S_INIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            period    <= P_INIT;
            spd_cnt   <= '0;
            lfsr      <= LFSR_SEED;
            step_cnt  <= '0;
            pend_dir  <= DIR_RIGHT;
            dir_q     <= DIR_RIGHT;
            first_run <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

            if (btn_dir_valid && state != S_INIT) pend_dir <= btn_dir;

            // The direction only moves right after a step, so the field sees
            // one heading for the whole period.
            if (state == S_INIT)  dir_q <= DIR_RIGHT;
            else if (step_int)    dir_q <= pend_dir;

            case (state)
                S_INIT: begin
                    tick_cnt  <= '0;
                    period    <= P_INIT;
                    spd_cnt   <= '0;
                    step_cnt  <= '0;
                    first_run <= 1'b1;
                end
                S_RUN: begin
                    first_run <= 1'b0;
                    if (step_int) begin
                        tick_cnt <= '0;
                        if (step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
                        if (spd_cnt == SPD_LAST) begin
                            spd_cnt <= '0;
                            period  <= period_dec;
                        end else begin
                            spd_cnt <= spd_cnt + 32'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start      = (state == S_INIT);
    assign step       = step_int;
    assign snake_dir  = dir_q;
    assign seed       = lfsr[SBITS-1:0];
    assign game_state = state;
    assign step_count = step_cnt;

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

    localparam int TI = 8;
    localparam int TM = 2;
    localparam int TD = 2;
    localparam int SS = 4;
    localparam int SB = 7;
`ifdef SNAKE_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_start = 1'b0;
    logic          btn_dir_valid = 1'b0;
    logic [1:0]    btn_dir = 2'd0;
    logic          btn_pause = 1'b0;
    logic          snake_alive = 1'b1;
    logic          start;
    logic          step;
    logic [1:0]    snake_dir;
    logic [SB-1:0] seed;
    logic [2:0]    game_state;
    logic [15:0]   step_count;

    snake_game_ctrl #(
        .TICKS_INIT(TI), .TICKS_MIN(TM), .TICKS_DEC(TD),
        .SPEEDUP_STEPS(SS), .SBITS(SB)
    ) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start),
        .btn_dir_valid(btn_dir_valid), .btn_dir(btn_dir),
        .btn_pause(btn_pause), .snake_alive(snake_alive),
        .start(start), .step(step), .snake_dir(snake_dir), .seed(seed),
        .game_state(game_state), .step_count(step_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model: game phase, cycles since last step, steps this game
    int          m_state = 0;
    int          m_el = 0;
    int          m_steps = 0;
    logic [15:0] m_count = 16'd0;
    logic [1:0]  m_dir = 2'd1;
    logic [1:0]  m_pend = 2'd1;
    bit          m_first = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;

    // outputs of the most recently checked cycle
    logic          s_step, s_start;
    logic [2:0]    s_state;
    logic [1:0]    s_dir;
    logic [15:0]   s_count;
    logic [SB-1:0] s_seed;
    int            s_cyc = 0;
    bit            dir0_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, got, exp, s_cyc);
        end
    endtask

    // step period in force after k steps of the current game
    function automatic int per(input int k);
        int p;
        p = TI - TD * (k / SS);
        return (p < TM) ? TM : p;
    endfunction

    task automatic tick();
        bit         death, e_step, e_start;
        logic [1:0] nd;
        #1;
        death   = (m_state == 2) && !m_first && !snake_alive;
        e_step  = (m_state == 2) && (m_el == per(m_steps) - 1) && !death;
        e_start = (m_state == 1);
        chk("start", 32'(start), 32'(e_start));
        chk("step", 32'(step), 32'(e_step));
        chk("state", 32'(game_state), 32'(m_state));
        chk("dir", 32'(snake_dir), 32'(m_dir));
        chk("count", 32'(step_count), 32'(m_count));
        chk("seed", 32'(seed), 32'(m_lfsr[SB-1:0]));
        s_step = step; s_start = start; s_state = game_state;
        s_dir = snake_dir; s_count = step_count; s_seed = seed;
        if (snake_dir == 2'd0) dir0_seen = 1'b1;
        s_cyc++;
        if (rst) begin
            m_state = 0; m_el = 0; m_steps = 0; m_count = 0;
            m_dir = 2'd1; m_pend = 2'd1; m_first = 0; m_lfsr = 16'hACE1;
        end else begin
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            nd = e_step ? m_pend : m_dir;
            if (btn_dir_valid && m_state != 1) m_pend = btn_dir;
            case (m_state)
                0: if (btn_start) m_state = 1;
                1: begin
                    m_count = 0; m_steps = 0; m_el = 0; m_first = 1;
                    nd = 2'd1; m_state = 2;
                end
                2: begin
                    m_first = 0;
                    if (e_step) begin
                        m_steps++; m_el = 0;
                        if (m_count != 16'hFFFF) m_count++;
                    end else m_el++;
                    if (btn_start) m_state = 1;
                    else if (death) m_state = 4;
                    else if (PAUSE_EN && btn_pause) m_state = 3;
                end
                3: if (btn_start) m_state = 1; else if (btn_pause) m_state = 2;
                4: if (btn_start) m_state = 1;
                default: m_state = 0;
            endcase
            m_dir = nd;
        end
        @(negedge clk);
        btn_start = 0; btn_dir_valid = 0; btn_pause = 0;
    endtask

    task automatic wait_step(input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (s_step) found = 1;
        end
        if (!found) chk("wait_step_timeout", 32'd0, 32'd1);
    endtask

    int exp_gaps[18] = '{8, 8, 8, 8, 6, 6, 6, 6, 4, 4, 4, 4, 2, 2, 2, 2, 2, 2};
    int step_cycles[$];
    int init_cyc;
    int n;
    logic [15:0] saved;

    initial begin
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        tick();
        chk("rst_state", 32'(s_state), 32'd0);
        chk("rst_dir", 32'(s_dir), 32'd1);
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_seed", 32'(s_seed), 32'h61);
        rst = 0;
        tick();

        // speed-up schedule
        btn_start = 1; tick();
        tick();
        chk("init_start", 32'(s_start), 32'd1);
        chk("init_state", 32'(s_state), 32'd1);
        init_cyc = s_cyc;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (s_step) step_cycles.push_back(s_cyc);
        end
        chk("steps_in_100", 32'(step_cycles.size()), 32'd26);
        for (int i = 0; i < 18 && i < step_cycles.size(); i++)
            chk($sformatf("gap%0d", i),
                32'(step_cycles[i] - ((i == 0) ? init_cyc : step_cycles[i-1])),
                32'(exp_gaps[i]));

        // direction latching: last request before the step wins
        btn_start = 1; tick();
        tick();
        wait_step(20);
        tick();
        dir0_seen = 0;
        btn_dir_valid = 1; btn_dir = 2'd0; tick();
        tick();
        btn_dir_valid = 1; btn_dir = 2'd3; tick();
        wait_step(20);
        chk("dir_hold_on_step", 32'(s_dir), 32'd1);
        tick();
        chk("dir_after_step", 32'(s_dir), 32'd3);
        chk("dir0_never", 32'(dir0_seen), 32'd0);

        // death and restart
        snake_alive = 0; tick();
        tick();
        chk("over_state", 32'(s_state), 32'd4);
        saved = s_count;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_step) n++;
        end
        chk("over_no_steps", 32'(n), 32'd0);
        chk("over_frozen", 32'(s_count), 32'(saved));
        btn_start = 1; tick();
        tick();
        chk("restart_init", 32'(s_state), 32'd1);
        tick();
        chk("restart_count", 32'(s_count), 32'd0);
        chk("restart_dir", 32'(s_dir), 32'd1);
        snake_alive = 1; tick();
        chk("first_run_mask", 32'(s_state), 32'd2);

        // death on the step cycle (offsets 3..7 then 8)
        repeat (5) tick();
        snake_alive = 0; tick();
        chk("death_beats_step", 32'(s_step), 32'd0);
        snake_alive = 1; tick();
        chk("death_step_over", 32'(s_state), 32'd4);

        // pause three cycles into a period
        btn_start = 1; tick();
        tick();
        wait_step(20);
        tick(); tick();
        btn_pause = 1; tick();
        tick();
        chk("pause_state", 32'(s_state), PAUSE_EN ? 32'd3 : 32'd2);
        repeat (48) tick();
        btn_pause = 1; tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (s_step) break;
        end
`ifdef SNAKE_PAUSE_EN
        chk("resume_gap", 32'(n), 32'd5);
`endif

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 999) < 3);
            btn_start     = ($urandom_range(0, 99) < 2);
            btn_dir_valid = ($urandom_range(0, 99) < 10);
            btn_dir       = 2'($urandom_range(0, 3));
            btn_pause     = ($urandom_range(0, 99) < 3);
            snake_alive   = ($urandom_range(0, 99) >= 3);
            tick();
        end
        rst = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Game sequencer for the snake playfield: turns player buttons into the field's one-cycle start/step strobes and a stable direction.
- Also supplies the free-running apple seed and a tick period that speeds up as play goes on.
- Sits between the input debouncers and the playfield; watches snake_alive to detect game over.

Parameters:
TICKS_INIT, 25000000, clk cycles between steps at game start (>= 2)
TICKS_MIN, 5000000, lower bound on step period (>= 2, <= TICKS_INIT)
TICKS_DEC, 1000000, period reduction applied at each speed-up
SPEEDUP_STEPS, 16, steps between speed-ups (>= 1)
SBITS, 7, width of seed output (matches playfield cell-index width)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
btn_start  in  1  one-cycle pulse, begin new game
btn_dir_valid  in  1  one-cycle pulse, btn_dir is valid
btn_dir  in  2  requested direction: 0 up, 1 right, 2 down, 3 left
btn_pause  in  1  one-cycle pulse, toggle pause (SNAKE_PAUSE_EN only)
snake_alive  in  1  playfield alive flag, combinational from the field
start  out  1  one-cycle playfield init strobe
step  out  1  one-cycle playfield advance strobe
snake_dir  out  2  direction presented to the playfield
seed  out  SBITS  apple seed, low SBITS of the LFSR
game_state  out  3  0 IDLE, 1 INIT, 2 RUN, 3 PAUSE, 4 OVER
step_count  out  16  steps issued this game, saturating at 16'hFFFF

Behaviour:
- Reset: state IDLE; start=0, step=0, snake_dir=1 (right), step_count=0; tick counter 0; period=TICKS_INIT; speed-up counter 0; LFSR=16'hACE1.
- LFSR:
  - 16-bit Galois, taps 0xB400, advances every cycle in every state.
  - Never reloaded except by rst, so it is never zero.
- IDLE:
  - btn_start -> INIT.
  - snake_alive is ignored (the reset field reads dead).
- INIT:
  - Lasts exactly one cycle; start=1 during it.
  - Clears step_count, tick counter and speed-up counter; period=TICKS_INIT; snake_dir=1. These match the playfield's initial heading right.
  - Next state RUN.
- RUN:
  - Tick counter increments each cycle.
  - When counter == period-1: step=1 for that cycle, counter -> 0, step_count += 1 (saturating), speed-up counter += 1.
  - When the speed-up counter reaches SPEEDUP_STEPS it clears, and period = max(period - TICKS_DEC, TICKS_MIN). Arithmetic is 32-bit unsigned with a clamp before subtract, so there is no underflow.
  - First step occurs exactly TICKS_INIT cycles after the INIT cycle.
- Direction:
  - btn_dir_valid loads a pending register in any state except INIT; the last request before a step wins.
  - snake_dir updates to the pending value only on the cycle after a step, so it is stable for a full period.
  - Reversal requests are passed through unchanged; the playfield rejects them.
- Death:
  - In RUN, snake_alive==0 is sampled each cycle, except the first RUN cycle (the field is still updating from start).
  - Low -> OVER next cycle; no step is issued in the cycle death is detected.
- OVER:
  - step and start are held 0; step_count is frozen.
  - btn_start -> INIT.
- btn_start in RUN or PAUSE: restarts via INIT (abandons the game).
- Simultaneous events:
  - A step tick and death detection in the same cycle: death wins, no step.
  - btn_start and btn_pause together: btn_start wins.
- rst mid-game: returns to IDLE on the next edge regardless of state; outputs take their reset values.

Optional Feature:
SNAKE_PAUSE_EN:
- Defined:
  - btn_pause in RUN -> PAUSE; the tick counter holds its value and no steps are issued.
  - btn_pause in PAUSE -> RUN; counting resumes from the held value, and the first-cycle alive masking does not reapply.
  - Direction requests are still latched while paused.
- Undefined: btn_pause is ignored, PAUSE (3) is never reported, and the PAUSE logic is not synthesised.

Test Plan:
- TICKS_INIT=8, TICKS_MIN=2, TICKS_DEC=2, SPEEDUP_STEPS=4; rst then btn_start with snake_alive=1 -> start high for one cycle; step pulses 8 cycles later.
- Steps 1-4 spaced 8 cycles, steps 5-8 spaced 6, then 4, then 2, staying at 2; step_count tracks exactly.
- Same parameters: btn_dir_valid dir=0 then dir=3 between two steps -> snake_dir becomes 3 the cycle after the next step; dir=0 is never output.
- Drop snake_alive in RUN -> game_state=4 next cycle, no further steps, step_count frozen; btn_start -> INIT, count resets to 0, snake_dir=1.
- Death detected on the cycle step would fire -> step stays 0 and the state goes to OVER; snake_alive=0 during the INIT cycle and first RUN cycle -> no transition to OVER.
- With SNAKE_PAUSE_EN: pause 3 cycles into a period, hold 50 cycles, resume -> next step 5 cycles after resume; without the macro, btn_pause has no effect.
